mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port synchronous RAM (1-cycle read latency) between instruction fetch and the
//   Execute-stage load/store interface. Arbitrates per cycle, steers store bytes to lanes, then
//   aligns and sign/zero-extends load data. Sits between IF/EX and the unified memory.
// PARAMETERS
//   ADDR_W        12  word-address width of the RAM (byte address bits [ADDR_W+1:2] used)
//   STARVE_LIMIT   4  consecutive denied IF cycles before IF gets one forced grant (1..15)
// PORTS
//   clk          in   1   clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   if_req       in   1   fetch request, held until if_gnt
//   if_addr      in   32  fetch byte address (word aligned)
//   if_flush     in   1   discard the fetch response returning this cycle (redirect)
//   if_gnt       out  1   fetch accepted this cycle
//   if_rvalid    out  1   fetch data valid
//   if_rdata     out  32  fetched word
//   d_rden       in   4   load byte-lane enables (Execute encoding); nonzero = load request
//   d_rden_sext  in   1   sign-extend load result
//   d_wren       in   4   store byte-lane enables; nonzero = store request
//   d_addr       in   32  data byte address
//   d_wdata      in   32  store data, unshifted (rs2)
//   d_gnt        out  1   data access accepted this cycle
//   d_rvalid     out  1   load result valid
//   d_rdata      out  32  aligned, extended load result
//   mem_en       out  1   RAM enable
//   mem_we       out  4   RAM byte write enables
//   mem_addr     out  ADDR_W  RAM word address
//   mem_wdata    out  32  RAM write data, lane-steered
//   mem_rdata    in   32  RAM read data, valid cycle after read enable
// BEHAVIOUR
//   Reset: starve_cnt=0, inflight_if=0, inflight_d=0, saved lane/sext regs=0; all outputs 0.
//   Data request: d_req = |d_rden | |d_wren. Both nonzero at once is illegal; store wins.
//   Grant (combinational, same cycle): d_req wins unless starve_cnt==STARVE_LIMIT and if_req,
//     then IF wins. Exactly one of if_gnt/d_gnt per cycle; none if no request.
//   starve_cnt: +1 (saturating) when if_req && !if_gnt; cleared when if_gnt or !if_req.
//   Issue: on grant mem_en=1, mem_addr=addr[ADDR_W+1:2]; store -> mem_we=d_wren; load/fetch -> 0.
//   Store steering: wren 1111 -> wdata; 0011/1100 -> {2{wdata[15:0]}};
//     0001/0010/0100/1000 -> {4{wdata[7:0]}}; other patterns -> wdata unchanged.
//   Response (registered, latency 1): inflight_if<=if_gnt; inflight_d<=d_gnt && load;
//     rden and sext captured on load grant. if_rvalid = inflight_if & ~if_flush;
//     if_rdata = mem_rdata. d_rvalid = inflight_d. Stores produce no response.
//   Load extract: rden 1111 -> word; 0011 -> [15:0]; 1100 -> [31:16]; 0001/0010/0100/1000 ->
//     byte lane 0/1/2/3; extended with lane MSB if sext else zero; other patterns -> raw word.
//   Back-to-back grants every cycle allowed; requester must hold req/addr until its gnt.
//   if_flush with inflight_if=0: no effect. Flush never blocks a same-cycle new grant.
//   Async reset mid-transaction: in-flight response dropped, no rvalid after release.
// TESTING
//   Lone if_req addr 0x40, mem word 0x00A00093 -> if_gnt cycle 0, if_rvalid/if_rdata=0x00A00093 cycle 1.
//   Store wren=0100 addr 0x102 wdata 0x000000AB -> mem_we=0100, mem_wdata=0xABABABAB, no d_rvalid.
//   Load rden=0010 sext=1, mem word 0x00008000 -> d_rdata=0xFFFFFF80; sext=0 -> 0x00000080.
//   if_req and d_req held 6 cycles, STARVE_LIMIT=4 -> d_gnt cycles 0-3, if_gnt cycle 4, d_gnt cycle 5.
//   Fetch granted cycle 0, if_flush=1 cycle 1 -> if_rvalid stays 0; fetch granted cycle 1 returns cycle 2.
//   rst_n low cycle after load grant -> d_rvalid never asserts; all outputs 0 during reset.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the Execute load/store unit, the
// arbiter and the unified single-port RAM. The arbiter uses the slave view.
// The master view is the combined core-plus-RAM side that surrounds it.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 12
);
  // instruction fetch side
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_flush;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;

  // Execute load/store side
  logic [3:0]        d_rden;
  logic              d_rden_sext;
  logic [3:0]        d_wren;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;

  // RAM side
  logic              mem_en;
  logic [3:0]        mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  if_req, if_addr, if_flush,
    output if_gnt, if_rvalid, if_rdata,
    input  d_rden, d_rden_sext, d_wren, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr, if_flush,
    input  if_gnt, if_rvalid, if_rdata,
    output d_rden, d_rden_sext, d_wren, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle read latency) between
// instruction fetch and the Execute load/store port. Data wins each cycle
// unless fetch has been denied STARVE_LIMIT cycles in a row. Store bytes are
// replicated onto their lanes; load data is aligned and sign/zero-extended on
// the way back. ADDR_W must be at most 29 so that byte-address bits above the
// word address exist.
//
// state      | meaning
// starve_cnt | consecutive cycles a pending fetch was denied (saturates at 15)
// inflight_if| a fetch read was issued last cycle; its data is on mem_rdata now
// inflight_d | a load read was issued last cycle; its data is on mem_rdata now
// rden/sext  | lane enables and extension mode of the most recently issued load
module mem_port_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_LIMIT);

  logic [3:0]  starve_cnt_q, starve_cnt_d;
  logic        inflight_if_q, inflight_if_d;
  logic        inflight_d_q, inflight_d_d;
  logic [3:0]  rden_q, rden_d;
  logic        sext_q, sext_d;

  logic        d_store;
  logic        d_load;
  logic        d_req;
  logic        if_win;
  logic        d_win;
  logic [31:0] wdata_steer;
  logic [31:0] load_word;

  // Only the word-address slice of either byte address reaches the RAM.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2], bus.if_addr[1:0],
                              bus.d_addr[31:ADDR_W+2], bus.d_addr[1:0]};

  // Request decode and per-cycle grant; a store overrides a simultaneous load.
  always_comb begin
    d_store = |bus.d_wren;
    d_load  = ~d_store & (|bus.d_rden);
    d_req   = d_store | d_load;
    if_win  = bus.if_req & (~d_req | (starve_cnt_q == STARVE_LIM));
    d_win   = d_req & ~if_win;
  end

  // Replicate narrow store data onto every lane so the byte enables pick it up.
  always_comb begin
    wdata_steer = bus.d_wdata;
    case (bus.d_wren)
      4'b0011, 4'b1100:                   wdata_steer = {2{bus.d_wdata[15:0]}};
      4'b0001, 4'b0010, 4'b0100, 4'b1000: wdata_steer = {4{bus.d_wdata[7:0]}};
      default:                            wdata_steer = bus.d_wdata;
    endcase
  end

  // Align the returning word according to the lanes captured at load issue.
  always_comb begin
    load_word = bus.mem_rdata;
    case (rden_q)
      4'b1111: load_word = bus.mem_rdata;
      4'b0011: load_word = {{16{sext_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:0]};
      4'b1100: load_word = {{16{sext_q & bus.mem_rdata[31]}}, bus.mem_rdata[31:16]};
      4'b0001: load_word = {{24{sext_q & bus.mem_rdata[7]}},  bus.mem_rdata[7:0]};
      4'b0010: load_word = {{24{sext_q & bus.mem_rdata[15]}}, bus.mem_rdata[15:8]};
      4'b0100: load_word = {{24{sext_q & bus.mem_rdata[23]}}, bus.mem_rdata[23:16]};
      4'b1000: load_word = {{24{sext_q & bus.mem_rdata[31]}}, bus.mem_rdata[31:24]};
      default: load_word = bus.mem_rdata;
    endcase
  end

  // Next-state: starvation counter, response tracking, load format capture.
  always_comb begin
    starve_cnt_d  = starve_cnt_q;
    inflight_if_d = if_win;
    inflight_d_d  = d_win & d_load;
    rden_d        = rden_q;
    sext_d        = sext_q;

    if (!bus.if_req || if_win) begin
      starve_cnt_d = 4'd0;
    end else if (starve_cnt_q != 4'hF) begin
      starve_cnt_d = starve_cnt_q + 4'd1;
    end

    if (d_win && d_load) begin
      rden_d = bus.d_rden;
      sext_d = bus.d_rden_sext;
    end
  end

  // State registers; reset also drops any response still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q  <= 4'd0;
      inflight_if_q <= 1'b0;
      inflight_d_q  <= 1'b0;
      rden_q        <= 4'd0;
      sext_q        <= 1'b0;
    end else begin
      starve_cnt_q  <= starve_cnt_d;
      inflight_if_q <= inflight_if_d;
      inflight_d_q  <= inflight_d_d;
      rden_q        <= rden_d;
      sext_q        <= sext_d;
    end
  end

  // Drive grants, RAM issue and responses; everything is held at 0 in reset.
  always_comb begin
    bus.if_gnt    = 1'b0;
    bus.d_gnt     = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 4'd0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    bus.if_rvalid = 1'b0;
    bus.if_rdata  = 32'd0;
    bus.d_rvalid  = 1'b0;
    bus.d_rdata   = 32'd0;

    if (rst_n) begin
      bus.if_gnt = if_win;
      bus.d_gnt  = d_win;
      bus.mem_en = if_win | d_win;

      if (if_win) begin
        bus.mem_addr = bus.if_addr[ADDR_W+1:2];
      end else if (d_win) begin
        bus.mem_addr = bus.d_addr[ADDR_W+1:2];
      end

      if (d_win && d_store) begin
        bus.mem_we    = bus.d_wren;
        bus.mem_wdata = wdata_steer;
      end

      // A redirect discards only the returning fetch word, never a new grant.
      bus.if_rvalid = inflight_if_q & ~bus.if_flush;
      bus.if_rdata  = bus.mem_rdata;
      bus.d_rvalid  = inflight_d_q;
      bus.d_rdata   = load_word;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table, hand-written multi-cycle
// sequences (starvation, flush, reset mid-load) and a randomized run checked
// against a lane/popcount based reference model.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(12)) bus ();

  mem_port_arbiter #(.ADDR_W(12), .STARVE_LIMIT(STARVE)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic        ir;   logic [31:0] ia;
    logic [3:0]  rd;   logic        sx;
    logic [3:0]  wr;   logic [31:0] da;   logic [31:0] wd;
    logic [31:0] rdat;
    logic        eig;  logic        edg;
    logic [3:0]  ewe;  logic [11:0] ea;   logic [31:0] ewd;
    logic        eiv;  logic        edv;  logic [31:0] eresp;
  } vec_t;

  vec_t vt[16];

  function automatic vec_t mk(logic ir, logic [31:0] ia, logic [3:0] rd, logic sx,
                              logic [3:0] wr, logic [31:0] da, logic [31:0] wd,
                              logic [31:0] rdat, logic eig, logic edg, logic [3:0] ewe,
                              logic [11:0] ea, logic [31:0] ewd, logic eiv, logic edv,
                              logic [31:0] eresp);
    vec_t v;
    v.ir = ir; v.ia = ia; v.rd = rd; v.sx = sx; v.wr = wr; v.da = da; v.wd = wd;
    v.rdat = rdat; v.eig = eig; v.edg = edg; v.ewe = ewe; v.ea = ea; v.ewd = ewd;
    v.eiv = eiv; v.edv = edv; v.eresp = eresp;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive_idle();
    bus.if_req = 0; bus.if_addr = 0; bus.if_flush = 0;
    bus.d_rden = 0; bus.d_rden_sext = 0; bus.d_wren = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus.mem_rdata = 0;
  endtask

  task automatic chk_all_zero(string tag);
    chk({tag, ".if_gnt"},    32'(bus.if_gnt), 0);
    chk({tag, ".d_gnt"},     32'(bus.d_gnt), 0);
    chk({tag, ".mem_en"},    32'(bus.mem_en), 0);
    chk({tag, ".mem_we"},    32'(bus.mem_we), 0);
    chk({tag, ".mem_addr"},  32'(bus.mem_addr), 0);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, 0);
    chk({tag, ".if_rvalid"}, 32'(bus.if_rvalid), 0);
    chk({tag, ".d_rvalid"},  32'(bus.d_rvalid), 0);
    chk({tag, ".if_rdata"},  bus.if_rdata, 0);
    chk({tag, ".d_rdata"},   bus.d_rdata, 0);
  endtask

  // Reference helpers: derived from lane count and lowest enabled lane.
  function automatic int low_lane(logic [3:0] en);
    for (int i = 0; i < 4; i++) if (en[i]) return i;
    return 0;
  endfunction

  function automatic logic [31:0] m_steer(logic [3:0] en, logic [31:0] d);
    int n = $countones(en);
    if (en == 4'b0011 || en == 4'b1100) return 32'(d[15:0]) * 32'h0001_0001;
    if (n == 1) return 32'(d[7:0]) * 32'h0101_0101;
    return d;
  endfunction

  function automatic logic [31:0] m_extract(logic [3:0] en, logic sx, logic [31:0] w);
    int width;
    logic [31:0] mask, val;
    if (en == 4'b0011 || en == 4'b1100) width = 16;
    else if ($countones(en) == 1) width = 8;
    else return w;
    mask = (32'd1 << width) - 1;
    val  = (w >> (8 * low_lane(en))) & mask;
    if (sx && val[width-1]) val = val | ~mask;
    return val;
  endfunction

  // Random-run stimulus registers and model state.
  logic        r_if_act, r_d_act;
  logic [31:0] r_if_addr, r_d_addr, r_wdata;
  logic [3:0]  r_rden, r_wren;
  logic        r_sext;
  int          m_wait;
  logic        m_if_back, m_ld_back, m_ld_sx;
  logic [3:0]  m_ld_en;

  function automatic logic [3:0] pick_en();
    case ($urandom_range(0, 9))
      0: return 4'b0001; 1: return 4'b0010; 2: return 4'b0100; 3: return 4'b1000;
      4: return 4'b0011; 5: return 4'b1100; 6, 7: return 4'b1111;
      default: return 4'($urandom_range(1, 15));
    endcase
  endfunction

  initial begin
    drive_idle();
    vt[0]  = mk(1, 32'h40, 0, 0, 0, 0, 0, 32'h00A00093, 1, 0, 0, 12'h010, 0, 1, 0, 32'h00A00093);
    vt[1]  = mk(0, 0, 0, 0, 4'b0100, 32'h102, 32'hAB, 32'h5555_5555, 0, 1, 4'b0100, 12'h040, 32'hABABABAB, 0, 0, 0);
    vt[2]  = mk(0, 0, 4'b0010, 1, 0, 32'h200, 0, 32'h00008000, 0, 1, 0, 12'h080, 0, 0, 1, 32'hFFFFFF80);
    vt[3]  = mk(0, 0, 4'b0010, 0, 0, 32'h200, 0, 32'h00008000, 0, 1, 0, 12'h080, 0, 0, 1, 32'h00000080);
    vt[4]  = mk(0, 0, 0, 0, 4'b1111, 32'h10, 32'h12345678, 0, 0, 1, 4'b1111, 12'h004, 32'h12345678, 0, 0, 0);
    vt[5]  = mk(0, 0, 0, 0, 4'b0011, 32'h08, 32'hCAFEBEEF, 0, 0, 1, 4'b0011, 12'h002, 32'hBEEFBEEF, 0, 0, 0);
    vt[6]  = mk(0, 0, 0, 0, 4'b0110, 32'h20, 32'h11223344, 0, 0, 1, 4'b0110, 12'h008, 32'h11223344, 0, 0, 0);
    vt[7]  = mk(0, 0, 4'b1100, 1, 0, 32'h30, 0, 32'h87651234, 0, 1, 0, 12'h00C, 0, 0, 1, 32'hFFFF8765);
    vt[8]  = mk(0, 0, 4'b1111, 1, 0, 32'h34, 0, 32'hDEADBEEF, 0, 1, 0, 12'h00D, 0, 0, 1, 32'hDEADBEEF);
    vt[9]  = mk(0, 0, 4'b1000, 0, 0, 32'h38, 0, 32'hF0000000, 0, 1, 0, 12'h00E, 0, 0, 1, 32'h000000F0);
    vt[10] = mk(0, 0, 4'b0001, 1, 0, 32'h3C, 0, 32'h0000007F, 0, 1, 0, 12'h00F, 0, 0, 1, 32'h0000007F);
    vt[11] = mk(1, 32'h80, 4'b1111, 0, 0, 32'h44, 0, 32'hAAAA5555, 0, 1, 0, 12'h011, 0, 0, 1, 32'hAAAA5555);
    vt[12] = mk(0, 0, 4'b1111, 0, 4'b0001, 32'h48, 32'h5A, 32'h1, 0, 1, 4'b0001, 12'h012, 32'h5A5A5A5A, 0, 0, 0);
    vt[13] = mk(0, 0, 4'b0101, 1, 0, 32'h4C, 0, 32'h01020304, 0, 1, 0, 12'h013, 0, 0, 1, 32'h01020304);
    vt[14] = mk(1, 32'hFFFFFFFC, 0, 0, 0, 0, 0, 32'h13579BDF, 1, 0, 0, 12'hFFF, 0, 1, 0, 32'h13579BDF);
    vt[15] = mk(0, 0, 0, 0, 0, 0, 0, 32'hFFFF0000, 0, 0, 0, 12'h000, 0, 0, 0, 0);

    // Reset state.
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk_all_zero("reset");
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: issue cycle then response cycle.
    for (int i = 0; i < 16; i++) begin
      bus.if_req = vt[i].ir; bus.if_addr = vt[i].ia;
      bus.d_rden = vt[i].rd; bus.d_rden_sext = vt[i].sx; bus.d_wren = vt[i].wr;
      bus.d_addr = vt[i].da; bus.d_wdata = vt[i].wd; bus.mem_rdata = 0;
      @(negedge clk);
      chk($sformatf("vec%0d.if_gnt", i), 32'(bus.if_gnt), 32'(vt[i].eig));
      chk($sformatf("vec%0d.d_gnt", i),  32'(bus.d_gnt),  32'(vt[i].edg));
      chk($sformatf("vec%0d.mem_en", i), 32'(bus.mem_en), 32'(vt[i].eig | vt[i].edg));
      chk($sformatf("vec%0d.mem_we", i), 32'(bus.mem_we), 32'(vt[i].ewe));
      if (vt[i].eig || vt[i].edg)
        chk($sformatf("vec%0d.mem_addr", i), 32'(bus.mem_addr), 32'(vt[i].ea));
      if (vt[i].ewe != 0)
        chk($sformatf("vec%0d.mem_wdata", i), bus.mem_wdata, vt[i].ewd);
      @(posedge clk); #1;
      drive_idle();
      bus.mem_rdata = vt[i].rdat;
      @(negedge clk);
      chk($sformatf("vec%0d.if_rvalid", i), 32'(bus.if_rvalid), 32'(vt[i].eiv));
      chk($sformatf("vec%0d.d_rvalid", i),  32'(bus.d_rvalid),  32'(vt[i].edv));
      if (vt[i].eiv) chk($sformatf("vec%0d.if_rdata", i), bus.if_rdata, vt[i].eresp);
      if (vt[i].edv) chk($sformatf("vec%0d.d_rdata", i),  bus.d_rdata,  vt[i].eresp);
      @(posedge clk); #1;
    end

    // Starvation: both requesters held for six cycles.
    bus.if_req = 1; bus.if_addr = 32'h100; bus.d_rden = 4'b1111; bus.d_addr = 32'h200;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("starve%0d.if_gnt", c), 32'(bus.if_gnt), 32'(c == 4));
      chk($sformatf("starve%0d.d_gnt", c),  32'(bus.d_gnt),  32'(c != 4));
      @(posedge clk); #1;
    end
    drive_idle();
    @(posedge clk); #1;

    // Flush: first fetch response discarded, second fetch issued same cycle returns.
    bus.if_req = 1; bus.if_addr = 32'h40;
    @(negedge clk);
    chk("flush.gnt0", 32'(bus.if_gnt), 1);
    @(posedge clk); #1;
    bus.if_flush = 1; bus.if_addr = 32'h44; bus.mem_rdata = 32'h11111111;
    @(negedge clk);
    chk("flush.rvalid1", 32'(bus.if_rvalid), 0);
    chk("flush.gnt1", 32'(bus.if_gnt), 1);
    @(posedge clk); #1;
    drive_idle(); bus.mem_rdata = 32'h22222222;
    @(negedge clk);
    chk("flush.rvalid2", 32'(bus.if_rvalid), 1);
    chk("flush.rdata2", bus.if_rdata, 32'h22222222);
    @(posedge clk); #1;
    bus.if_flush = 1;
    @(negedge clk);
    chk("flush.idle", 32'(bus.if_rvalid), 0);
    @(posedge clk); #1;
    drive_idle();

    // Reset in the cycle after a load grant.
    bus.d_rden = 4'b1111; bus.d_addr = 32'h80;
    @(negedge clk);
    chk("rst.ld_gnt", 32'(bus.d_gnt), 1);
    @(posedge clk); #1;
    rst_n = 1'b0; bus.if_req = 1; bus.mem_rdata = 32'hFFFFFFFF;
    @(negedge clk);
    chk_all_zero("rst_mid");
    @(posedge clk); #1;
    drive_idle();
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("rst_after%0d.d_rvalid", c), 32'(bus.d_rvalid), 0);
      @(posedge clk); #1;
    end

    // Randomized run against the reference model.
    r_if_act = 0; r_d_act = 0; r_if_addr = 0; r_d_addr = 0; r_wdata = 0;
    r_rden = 0; r_wren = 0; r_sext = 0;
    m_wait = 0; m_if_back = 0; m_ld_back = 0; m_ld_en = 0; m_ld_sx = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic dreq, dstore, if_win, d_win;
      logic [31:0] e_addr;
      if (!r_if_act && $urandom_range(0, 2) != 0) begin
        r_if_act = 1; r_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (!r_d_act && $urandom_range(0, 2) != 0) begin
        r_d_act = 1; r_d_addr = $urandom; r_wdata = $urandom; r_sext = 1'($urandom);
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin r_rden = pick_en(); r_wren = 0; end
          9:             begin r_rden = pick_en(); r_wren = pick_en(); end
          default:       begin r_rden = 0; r_wren = pick_en(); end
        endcase
      end
      bus.if_req = r_if_act; bus.if_addr = r_if_addr;
      bus.d_rden = r_d_act ? r_rden : 4'd0; bus.d_wren = r_d_act ? r_wren : 4'd0;
      bus.d_rden_sext = r_sext; bus.d_addr = r_d_addr; bus.d_wdata = r_wdata;
      bus.if_flush = ($urandom_range(0, 3) == 0);
      bus.mem_rdata = $urandom;

      dreq   = r_d_act;
      dstore = r_d_act && (r_wren != 0);
      if_win = r_if_act && (!dreq || m_wait == STARVE);
      d_win  = dreq && !if_win;
      e_addr = if_win ? 32'(r_if_addr[13:2]) : 32'(r_d_addr[13:2]);

      @(negedge clk);
      chk("rnd.if_gnt", 32'(bus.if_gnt), 32'(if_win));
      chk("rnd.d_gnt",  32'(bus.d_gnt),  32'(d_win));
      chk("rnd.mem_en", 32'(bus.mem_en), 32'(if_win || d_win));
      chk("rnd.mem_we", 32'(bus.mem_we), (d_win && dstore) ? 32'(r_wren) : 32'd0);
      if (if_win || d_win) chk("rnd.mem_addr", 32'(bus.mem_addr), e_addr);
      if (d_win && dstore) chk("rnd.mem_wdata", bus.mem_wdata, m_steer(r_wren, r_wdata));
      chk("rnd.if_rvalid", 32'(bus.if_rvalid), 32'(m_if_back && !bus.if_flush));
      chk("rnd.d_rvalid",  32'(bus.d_rvalid),  32'(m_ld_back));
      if (m_if_back && !bus.if_flush) chk("rnd.if_rdata", bus.if_rdata, bus.mem_rdata);
      if (m_ld_back) chk("rnd.d_rdata", bus.d_rdata, m_extract(m_ld_en, m_ld_sx, bus.mem_rdata));

      if (!r_if_act || if_win) m_wait = 0;
      else if (m_wait < 15) m_wait++;
      m_if_back = if_win;
      m_ld_back = d_win && !dstore;
      if (m_ld_back) begin m_ld_en = r_rden; m_ld_sx = r_sext; end
      if (if_win) r_if_act = 0;
      if (d_win)  r_d_act  = 0;
      @(posedge clk); #1;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
